// File: rtl/tpu_pkg.sv
// tpu_pkg: shared state encoding, width derivations and result formatting for matmul_ctrl.
// Contents: state_t (LOAD, CALC, DONE), accw_f / iw_f width helpers, fmt result formatter.
// Build option: SATURATE_EN selects clamping in fmt; otherwise results wrap to OW bits.
package tpu_pkg;

    typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;

    function automatic int accw_f(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int iw_f(input int n);
        return $clog2(n * n);
    endfunction

    // The caller keeps the low ow bits of the return value.
    function automatic logic signed [63:0] fmt(input logic signed [63:0] v, input int ow);
`ifdef SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        return v > hi ? hi : v < lo ? lo : v;
`else
        return v & ((64'sd1 <<< ow) - 64'sd1);
`endif
    endfunction

endpackage

// File: rtl/mac_unit.sv
// mac_unit: signed multiply-accumulate with clear-on-write and formatted result output.
// Ports: clk, rst_n (async active-low), clr (sync zero), en (accumulate this cycle),
//        last (final term: emit result and restart accumulation), a, b (DW-bit signed
//        operands), res (OW-bit fmt of acc + a*b, combinational).
// Build option: SATURATE_EN (through tpu_pkg::fmt).
module mac_unit import tpu_pkg::*; #(
    parameter int DW   = 8,
    parameter int OW   = 8,
    parameter int ACCW = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 last,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [OW-1:0] res
);

    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] prod;
    logic signed [ACCW-1:0] sum;

    assign prod = ACCW'(a) * ACCW'(b);
    assign sum  = acc + prod;
    assign res  = OW'(fmt(64'(sum), OW));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= last ? '0 : sum;
    end

endmodule

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: N x N signed matrix multiply controller, C = A x B, one MAC per cycle.
// Ports: clk, rst_n (async active-low); load_en/load_sel_ab/load_index/in_data write A (0)
//        or B (1) row-major; clear aborts to LOAD; output_en/output_sel read C through
//        out_data (0 outside DONE); load_ready/busy/done flag LOAD/CALC/DONE.
// Build option: SATURATE_EN clamps results instead of wrapping.
module matmul_ctrl import tpu_pkg::*; #(
    parameter  int N    = 2,
    parameter  int DW   = 8,
    parameter  int OW   = 8,
    localparam int ACCW = accw_f(N, DW),
    localparam int IW   = iw_f(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_en,
    input  logic                 load_sel_ab,
    input  logic [IW-1:0]        load_index,
    input  logic signed [DW-1:0] in_data,
    input  logic                 clear,
    input  logic                 output_en,
    input  logic [IW-1:0]        output_sel,
    output logic signed [OW-1:0] out_data,
    output logic                 load_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int NN = N * N;
    localparam int CW = $clog2(N);

    state_t state, next;
    logic signed [DW-1:0] a_mem [NN];
    logic signed [DW-1:0] b_mem [NN];
    logic signed [OW-1:0] c_mem [NN];
    logic signed [OW-1:0] res;
    logic [NN-1:0] a_valid, b_valid;
    logic [CW-1:0] i, j, k;
    logic [IW-1:0] a_idx, b_idx, c_idx;
    logic full, k_end, j_end, i_end, wr;

    assign full  = &a_valid && &b_valid;
    assign k_end = k == CW'(N - 1);
    assign j_end = j == CW'(N - 1);
    assign i_end = i == CW'(N - 1);
    // Once the masks are full the start is committed, so further writes are dropped.
    assign wr    = state == LOAD && !full && load_en && !clear && 32'(load_index) < NN;
    assign a_idx = IW'(int'(i) * N + int'(k));
    assign b_idx = IW'(int'(k) * N + int'(j));
    assign c_idx = IW'(int'(i) * N + int'(j));

    assign load_ready = state == LOAD;
    assign busy       = state == CALC;
    assign done       = state == DONE;
    assign out_data   = (output_en && state == DONE && 32'(output_sel) < NN) ? c_mem[output_sel] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= LOAD;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        if (clear)
            next = LOAD;
        else if (state == LOAD && full)
            next = CALC;
        else if (state == CALC && k_end && j_end && i_end)
            next = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NN; n++) begin
                a_mem[n] <= '0;
                b_mem[n] <= '0;
            end
            a_valid <= '0;
            b_valid <= '0;
        end else if (clear) begin
            a_valid <= '0;
            b_valid <= '0;
        end else if (wr) begin
            if (load_sel_ab) begin
                b_mem[load_index]   <= in_data;
                b_valid[load_index] <= 1'b1;
            end else begin
                a_mem[load_index]   <= in_data;
                a_valid[load_index] <= 1'b1;
            end
        end
    end

    // Counters idle at zero outside CALC and wrap back to zero after the final MAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i <= '0;
            j <= '0;
            k <= '0;
            for (int n = 0; n < NN; n++)
                c_mem[n] <= '0;
        end else if (clear) begin
            i <= '0;
            j <= '0;
            k <= '0;
            for (int n = 0; n < NN; n++)
                c_mem[n] <= '0;
        end else if (state == CALC) begin
            k <= k_end ? '0 : k + CW'(1);
            if (k_end) begin
                c_mem[c_idx] <= res;
                j <= j_end ? '0 : j + CW'(1);
                if (j_end)
                    i <= i_end ? '0 : i + CW'(1);
            end
        end
    end

    mac_unit #(.DW(DW), .OW(OW), .ACCW(ACCW)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear || state != CALC),
        .en    (state == CALC),
        .last  (k_end),
        .a     (a_mem[a_idx]),
        .b     (b_mem[b_idx]),
        .res   (res)
    );

endmodule

// File: tb/tb_matmul_ctrl.sv
// tb_matmul_ctrl: directed and randomized checks of matmul_ctrl (N=2, DW=8, OW=8) against a
// plain-arithmetic matrix product model. Honors SATURATE_EN for the expected formatting.
module tb_matmul_ctrl;

    logic       clk = 0, rst_n = 0, load_en = 0, load_sel_ab = 0, clear = 0, output_en = 0;
    logic [1:0] load_index = 0, output_sel = 0;
    logic [7:0] in_data = 0;
    logic [7:0] out_data;
    logic       load_ready, busy, done;
    int         checks = 0, failures = 0;
    int         ma [4];
    int         mb [4];
    logic [7:0] exp_c [4];
    bit         seen_done;

    always #5 clk = ~clk;

    matmul_ctrl #(.N(2), .DW(8), .OW(8)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_sel_ab(load_sel_ab),
        .load_index(load_index), .in_data(in_data), .clear(clear), .output_en(output_en),
        .output_sel(output_sel), .out_data(out_data), .load_ready(load_ready),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int fm(input int s);
`ifdef SATURATE_EN
        return s > 127 ? 127 : s < -128 ? -128 : s;
`else
        return s;
`endif
    endfunction

    task automatic model();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                int s, v;
                s = 0;
                for (int t = 0; t < 2; t++)
                    s += ma[r*2+t] * mb[t*2+c];
                v = fm(s);
                exp_c[r*2+c] = v[7:0];
            end
    endtask

    task automatic randomize_mats();
        for (int n = 0; n < 4; n++) begin
            ma[n] = int'($urandom_range(0, 255)) - 128;
            mb[n] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic wr(input bit s, input int idx, input int d);
        load_en = 1;
        load_sel_ab = s;
        load_index = idx[1:0];
        in_data = d[7:0];
        step();
        load_en = 0;
    endtask

    // Loads all eight elements in random order; extra leaves a bogus write pending for edge t+1.
    task automatic load_all(input bit extra);
        int order [8];
        for (int n = 0; n < 8; n++) order[n] = n;
        for (int n = 7; n > 0; n--) begin
            int r, tmp;
            r = int'($urandom_range(0, n));
            tmp = order[n]; order[n] = order[r]; order[r] = tmp;
        end
        for (int n = 0; n < 8; n++) begin
            int idx;
            idx = order[n] % 4;
            load_en = 1;
            load_sel_ab = order[n] >= 4;
            load_index = idx[1:0];
            in_data = order[n] >= 4 ? mb[idx][7:0] : ma[idx][7:0];
            step();
        end
        if (extra) begin
            load_sel_ab = 0;
            load_index = 0;
            in_data = 8'd55;
        end else
            load_en = 0;
    endtask

    task automatic wait_done(input string tag);
        int cnt;
        for (cnt = 1; cnt <= 50; cnt++) begin
            step();
            load_en = 0;
            if (cnt == 1) check({tag, "_busy"}, 32'(busy), 1);
            if (done) break;
        end
        check({tag, "_latency"}, cnt, 9);
    endtask

    task automatic read_check(input string tag);
        output_en = 0;
        output_sel = 0;
        #1 check({tag, "_out_disabled"}, 32'(out_data), 0);
        for (int n = 0; n < 4; n++) begin
            output_en = 1;
            output_sel = n[1:0];
            #1 check($sformatf("%s_c%0d", tag, n), 32'(out_data), 32'(exp_c[n]));
        end
        output_en = 0;
    endtask

    task automatic pulse_clear();
        clear = 1;
        step();
        clear = 0;
    endtask

    task automatic run(input string tag, input bit extra);
        model();
        load_all(extra);
        wait_done(tag);
        read_check(tag);
    endtask

    initial begin
        output_en = 1;
        #3;
        check("rst_load_ready", 32'(load_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_out", 32'(out_data), 0);
        output_en = 0;
        #10 rst_n = 1;
        step();

        ma = '{1, 2, 3, 4};
        mb = '{5, 6, 7, 8};
        run("basic", 1);
        check("basic_c0_const", 32'(exp_c[0]), 19);

        pulse_clear();
        check("clear_to_load", 32'(load_ready), 1);
        ma = '{-1, 0, 0, -1};
        mb = '{3, 4, 5, 6};
        run("signed", 0);

        pulse_clear();
        ma = '{100, 100, 100, 100};
        mb = '{100, 100, 100, 100};
        run("overflow", 0);

        for (int r = 0; r < 3; r++) begin
            pulse_clear();
            randomize_mats();
            run($sformatf("rand%0d", r), 0);
        end

        pulse_clear();
        randomize_mats();
        ma[0] = 1;
        model();
        wr(0, 0, 9);
        wr(0, 0, 1);
        for (int n = 1; n < 4; n++) wr(0, n, ma[n]);
        for (int n = 0; n < 3; n++) wr(1, n, mb[n]);
        repeat (3) step();
        check("partial_busy", 32'(busy), 0);
        check("partial_ready", 32'(load_ready), 1);
        wr(1, 3, mb[3]);
        wait_done("overwrite");
        read_check("overwrite");

        pulse_clear();
        randomize_mats();
        model();
        load_all(0);
        step();
        step();
        check("abort_busy_before", 32'(busy), 1);
        pulse_clear();
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(load_ready), 1);
        seen_done = 0;
        repeat (20) begin
            step();
            seen_done |= done;
        end
        check("abort_no_done", 32'(seen_done), 0);
        run("abort_reload", 0);

        pulse_clear();
        randomize_mats();
        model();
        load_all(0);
        step();
        step();
        output_en = 1;
        output_sel = 0;
        #2 rst_n = 0;
        #1;
        check("arst_done", 32'(done), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_out", 32'(out_data), 0);
        check("arst_ready", 32'(load_ready), 1);
        #2 rst_n = 1;
        output_en = 0;
        step();
        randomize_mats();
        run("post_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
